// File: rtl/obi_data_arbiter.sv
// Two-master, one-slave OBI data-port arbiter with round-robin priority, grant lock
// and an in-order outstanding-ID FIFO that routes each response back to its issuer.
module obi_data_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [1:0]                            m_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]            m_addr_i,
    input  logic [1:0]                            m_we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]          m_be_i,
    input  logic [1:0][DATA_WIDTH-1:0]            m_wdata_i,
    output logic [1:0]                            m_gnt_o,
    output logic [1:0]                            m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic                                  s_req_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic                                  s_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_be_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic                                  s_gnt_i,
    input  logic                                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic                                  err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Pointers wrap at the FIFO depth, which need not fill the pointer range.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    logic                       sel_q, sel_d;
    logic                       lock_q, lock_d;
    logic                       prio_q, prio_d;
    logic                       err_q, err_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic sel_s;
    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    // Master selection: a locked request keeps its master, otherwise round-robin.
    always_comb begin
        sel_s = prio_q;
        if (lock_q) begin
            sel_s = sel_q;
        end else begin
            case (m_req_i)
                2'b01:   sel_s = 1'b0;
                2'b10:   sel_s = 1'b1;
                default: sel_s = prio_q;
            endcase
        end
    end

    // Slave request channel muxing and handshake decode.
    always_comb begin
        full_s    = (cnt_q == CNT_MAX);
        empty_s   = (cnt_q == {CNT_W{1'b0}});
        head_s    = fifo_q[rptr_q];
        s_req_o   = m_req_i[sel_s] & ~full_s;
        s_addr_o  = m_addr_i[sel_s];
        s_we_o    = m_we_i[sel_s];
        s_be_o    = m_be_i[sel_s];
        s_wdata_o = m_wdata_i[sel_s];
        push_s    = s_req_o & s_gnt_i;
        pop_s     = s_rvalid_i & ~empty_s;
        m_gnt_o   = 2'b00;
        if (push_s) begin
            m_gnt_o[sel_s] = 1'b1;
        end else begin
            m_gnt_o = 2'b00;
        end
        m_rvalid_o = 2'b00;
        if (pop_s) begin
            m_rvalid_o[head_s] = 1'b1;
        end else begin
            m_rvalid_o = 2'b00;
        end
        m_rdata_o     = s_rdata_i;
        outstanding_o = cnt_q;
        err_o         = err_q;
    end

    // Next-state for arbitration, outstanding FIFO and error flag.
    always_comb begin
        sel_d  = sel_s;
        lock_d = s_req_o & ~s_gnt_i;
        prio_d = prio_q;
        err_d  = err_q | (s_rvalid_i & empty_s);
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_s) begin
            prio_d         = ~sel_s;
            fifo_d[wptr_q] = sel_s;
            wptr_d         = ptr_next(wptr_q);
        end else begin
            prio_d = prio_q;
        end
        if (pop_s) begin
            rptr_d = ptr_next(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset flushes the FIFO, lock and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q  <= 1'b0;
            lock_q <= 1'b0;
            prio_q <= 1'b0;
            err_q  <= 1'b0;
            fifo_q <= {MAX_OUTSTANDING{1'b0}};
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            sel_q  <= sel_d;
            lock_q <= lock_d;
            prio_q <= prio_d;
            err_q  <= err_d;
            fifo_q <= fifo_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: doc/obi_data_arbiter.md
# obi_data_arbiter

Two-master, one-slave arbiter for the OBI-style data port (req/gnt/rvalid) in front of the memory-mapped RAM of the core test subsystem. Master 0 is the core data interface and master 1 is an auxiliary requester, such as a bench loader or a DMA model. The block picks one master per address phase with round-robin fairness and holds that choice until the slave grants. It records the granting master in an in-order outstanding FIFO so each response is routed back to the master that issued it.

## Interface
Parameters:
- ADDR_WIDTH, default 32: address width of masters and slave.
- DATA_WIDTH, default 32: read/write data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, default 2: depth of the outstanding-ID FIFO; a power of 2, minimum 1.

Ports (clock and reset first):
- clk_i  in  1  single clock; all state is updated on its rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- m_req_i  in  2  per-master request (bit 0 = core, bit 1 = aux).
- m_addr_i  in  2xADDR_WIDTH  per-master address.
- m_we_i  in  2  per-master write enable.
- m_be_i  in  2xDATA_WIDTH/8  per-master byte enables.
- m_wdata_i  in  2xDATA_WIDTH  per-master write data.
- m_gnt_o  out  2  per-master grant.
- m_rvalid_o  out  2  per-master response valid.
- m_rdata_o  out  DATA_WIDTH  read data, broadcast to both masters; valid only where m_rvalid_o is set.
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  slave request channel.
- s_gnt_i  in  1  slave grant.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DATA_WIDTH  slave read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  count of granted transactions not yet answered.
- err_o  out  1  sticky protocol error flag.

## Operation
- State:
  - sel_q: the master currently presented to the slave.
  - lock_q: set while a presented request is waiting for grant.
  - prio_q: the master that has priority on the next fresh arbitration.
  - ID FIFO: 1 bit per entry, with read/write pointers and a count.
- Fresh arbitration (lock_q=0):
  - If only one master requests, that master is selected.
  - If both request, prio_q is selected.
  - If neither requests, sel = prio_q and s_req_o=0.
- Lock:
  - If s_req_o=1 and s_gnt_i=0, lock_q<=1 and sel is held at sel_q next cycle, regardless of the other master.
  - lock_q clears on the cycle that grant occurs.
- Request forwarding:
  - s_req_o = m_req_i[sel] & (count < MAX_OUTSTANDING).
  - All s_* request fields mux from master sel.
- Grant:
  - m_gnt_o[i] = s_gnt_i & s_req_o & (sel==i).
  - On grant, the FIFO pushes sel and prio_q <= ~sel.
- Response:
  - m_rvalid_o[i] = s_rvalid_i & (count>0) & (FIFO head==i).
  - On s_rvalid_i with count>0, the FIFO pops.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FIFO full (count==MAX_OUTSTANDING): s_req_o is masked to 0, lock is not entered, and no grant is possible. A pop in that cycle does not enable a push until the next cycle.
- Error: s_rvalid_i while count==0 sets err_o. That response is dropped, with no m_rvalid_o and no pop. err_o clears only on reset.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Address phase is combinational: m_gnt_o follows s_gnt_i in the same cycle, and s_* request fields follow m_* in the same cycle.
- Response routing is combinational: zero added latency.
- Responses return in order, at least 1 cycle after their grant. A same-cycle rvalid with count==0 counts as an error, even alongside a grant.
- Reset values:
  - sel_q=0, lock_q=0, prio_q=0 (core first).
  - FIFO empty, outstanding_o=0, err_o=0.
  - s_req_o=0 and all m_gnt_o/m_rvalid_o=0 unless driven combinationally by inputs after reset.
- Reset asserted mid-transaction flushes the FIFO and lock immediately. Responses arriving after reset release set err_o.

## Test plan
- Single master: core requests a read of addr 0x180; slave grants in the same cycle and gives rvalid 2 cycles later with 0xDEADBEEF. Required: m_gnt_o=01, then m_rvalid_o=01 with m_rdata_o=0xDEADBEEF; outstanding_o goes 0→1→0.
- Contention: both masters hold req for 4 grants. Required: grant order core, aux, core, aux; each response is routed to its issuer.
- Lock: aux alone requests while s_gnt_i=0 for 3 cycles, and core raises req in cycle 2. Required: s_addr_o stays at aux's address and aux is granted first; core is granted next.
- Full FIFO: MAX_OUTSTANDING=2, two grants with no rvalid. Required: s_req_o=0 while count=2. Next cycle after one rvalid, s_req_o=1.
- Error: s_rvalid_i pulsed with outstanding_o=0. Required: err_o=1 from the next cycle onward, m_rvalid_o=00, and err_o holds until rst_ni=0.
- Reset mid-operation: assert rst_ni=0 with outstanding_o=2. Required: outputs return to reset values asynchronously, and arbitration restarts with core priority.
